pc_redirect_unit: RTL and testbench

//  Fetch-stage PC register and branch/jump redirect controller, directly downstream of shift_left_2.

---
 rtl/pc_redirect_unit.sv | 154 +++++++++++++++
 tb/tb_pc_redirect_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Fetch-stage PC register and branch/jump redirect controller. Forms the
//   branch target from the branch's PC+4 plus the pre-shifted offset, picks
//   the next PC (sequential, branch, jump or hold) and raises if_flush for
//   FLUSH_CYCLES cycles after every accepted redirect.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   stall          hold the PC (load-use hazard)
//   branch_taken   branch resolved taken this cycle
//   branch_pc4     PC+4 of the resolving branch
//   branch_off_sl2 sign-extended offset, already shifted left by 2
//   jump           unconditional jump decoded this cycle
//   jump_index     instruction[25:0] of the jump
//   pc             current fetch address (registered)
//   pc_plus4       pc + 4 (combinational, wraps)
//   if_flush       kill the wrong-path instruction in IF/ID
//   redirect_pc    target of the last accepted redirect (registered)
//   misalign_trap  one-cycle pulse after a misaligned redirect
//
// Configuration
//   MISALIGN_TRAP_EN  defined: a misaligned target loads TRAP_VECTOR and
//                     pulses misalign_trap. Undefined: target bits [1:0]
//                     are cleared and misalign_trap is tied low.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [31:0] branch_off_sl2,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_flush,
  output logic [31:0] redirect_pc,
  output logic        misalign_trap
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  // Counter load value: the redirect cycle itself is the first flush cycle.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rpc_q, rpc_d;

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;
  logic [31:0] seq_pc;
  logic        redirect_req;

  assign pc_plus4     = pc_q + 32'd4;
  assign br_tgt       = branch_pc4 + branch_off_sl2;
  assign j_tgt        = {pc_plus4[31:28], jump_index, 2'b00};
  // Branch beats jump when both arrive together.
  assign tgt_raw      = branch_taken ? br_tgt : j_tgt;
  assign redirect_req = branch_taken | jump;
  assign seq_pc       = stall ? pc_q : pc_plus4;

`ifdef MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic tgt_misaligned;

  assign tgt            = tgt_raw;
  assign tgt_misaligned = (tgt_raw[1:0] != 2'b00);
  assign misalign_trap  = trap_q;
`else
  assign tgt            = tgt_raw & ~32'h0000_0003;
  assign misalign_trap  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    rpc_d    = rpc_q;
    if_flush = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_d   = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        if (redirect_req) begin
          if_flush = 1'b1;
          rpc_d    = tgt;
          pc_d     = tgt;
`ifdef MISALIGN_TRAP_EN
          if (tgt_misaligned) begin
            pc_d   = TRAP_VECTOR;
            trap_d = 1'b1;
          end
`endif
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_INIT;
          end
        end else begin
          pc_d = seq_pc;
        end
      end
      ST_FLUSH: begin
        // Redirect requests here belong to the wrong path and are dropped.
        if_flush = 1'b1;
        pc_d     = seq_pc;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
    if (reset) begin
      if_flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
`ifdef MISALIGN_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0080;
`ifdef MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_pc4, branch_off_sl2;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4, redirect_pc;
  logic        if_flush, misalign_trap;

  always #5 clk = ~clk;

  pc_redirect_unit #(
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_pc4    (branch_pc4),
    .branch_off_sl2(branch_off_sl2),
    .jump          (jump),
    .jump_index    (jump_index),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .if_flush      (if_flush),
    .redirect_pc   (redirect_pc),
    .misalign_trap (misalign_trap)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: fetch address, last redirect, remaining flush cycles.
  logic [31:0] m_pc, m_rpc;
  int          m_left;
  logic        m_trap;
  bit          m_valid = 1'b0;

  logic s_flush, s_trap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    if (reset) begin
      m_pc = RESET_PC; m_rpc = RESET_PC; m_left = 0; m_trap = 1'b0;
    end else if (m_left > 0) begin
      m_left--; m_trap = 1'b0;
      if (!stall) m_pc = m_pc + 32'd4;
    end else if (branch_taken || jump) begin
      logic [31:0] p4;
      p4  = m_pc + 32'd4;
      tgt = branch_taken ? branch_pc4 + branch_off_sl2 : {p4[31:28], jump_index, 2'b00};
      m_left = FLUSH_CYCLES - 1;
      if (MIS && tgt[1:0] != 2'b00) begin
        m_pc = TRAP_VECTOR; m_rpc = tgt; m_trap = 1'b1;
      end else begin
        tgt[1:0] = 2'b00;
        m_pc = tgt; m_rpc = tgt; m_trap = 1'b0;
      end
    end else begin
      m_trap = 1'b0;
      if (!stall) m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock cycle: drive, sample combinational outputs mid-cycle,
  // advance model at the edge, sample registered outputs just after it.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] p4,
                      input logic [31:0] off, input logic j, input logic [25:0] ji);
    reset = r; stall = s; branch_taken = b; branch_pc4 = p4;
    branch_off_sl2 = off; jump = j; jump_index = ji;
    @(negedge clk);
    s_flush = if_flush;
    s_trap  = misalign_trap;
    check("if_flush_zero_in_reset", {31'd0, r ? if_flush : 1'b0}, 32'd0);
    if (m_valid) begin
      check("if_flush", {31'd0, if_flush}, {31'd0, !r && (m_left > 0 || b || j)});
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trap});
    end
    @(posedge clk);
    model_edge();
    if (r) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      check("pc", pc, m_pc);
      check("redirect_pc", redirect_pc, m_rpc);
    end
    $display("t=%0t rst=%0b stl=%0b br=%0b j=%0b flush=%0b trap=%0b pc=%08h rpc=%08h",
             $time, r, s, b, j, s_flush, s_trap, pc, redirect_pc);
  endtask

  typedef struct {
    logic        rst, stl, br;
    logic [31:0] pc4, off;
    logic        jmp;
    logic [25:0] jidx;
    logic        exp_flush, exp_trap;
    logic [31:0] exp_pc, exp_rpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stl, logic br, logic [31:0] pc4, logic [31:0] off,
                              logic jmp, logic [25:0] jidx, logic ef, logic et,
                              logic [31:0] ep, logic [31:0] er);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.pc4 = pc4; v.off = off; v.jmp = jmp; v.jidx = jidx;
    v.exp_flush = ef; v.exp_trap = et; v.exp_pc = ep; v.exp_rpc = er;
    return v;
  endfunction

  initial begin
    logic [31:0] mis_pc, mis_rpc;
    mis_pc  = MIS ? 32'h80  : 32'h100;
    mis_rpc = MIS ? 32'h102 : 32'h100;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_pc4 = '0; branch_off_sl2 = '0; jump_index = '0;

    // reset, sequential fetch
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,0, 32'h0, 32'h0));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,0, 32'h0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 32'h4, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 32'h8, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 32'hC, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 32'h10, 32'h0));
    // backward branch at pc=0x10
    vecs.push_back(mk(0,0,1,32'h14,32'hFFFF_FFF0,0,0, 1,0, 32'h4, 32'h4));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,0, 32'h8, 32'h4));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 32'hC, 32'h4));
    // stall ignored by branch, then stall holds
    vecs.push_back(mk(0,1,1,32'h100,32'h20,0,0, 1,0, 32'h120, 32'h120));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,0, 32'h120, 32'h120));
    vecs.push_back(mk(0,1,0,0,0,0,0, 0,0, 32'h120, 32'h120));
    vecs.push_back(mk(0,1,0,0,0,0,0, 0,0, 32'h120, 32'h120));
    // get to 0x3000_0000, jump, jump in flush ignored
    vecs.push_back(mk(0,0,1,32'h3000_0000,32'h0,0,0, 1,0, 32'h3000_0000, 32'h3000_0000));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,0, 32'h3000_0000, 32'h3000_0000));
    vecs.push_back(mk(0,0,0,0,0,1,26'h40, 1,0, 32'h3000_0100, 32'h3000_0100));
    vecs.push_back(mk(0,0,0,0,0,1,26'h80, 1,0, 32'h3000_0104, 32'h3000_0100));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 32'h3000_0108, 32'h3000_0100));
    // branch and jump together: branch wins
    vecs.push_back(mk(0,0,1,32'h200,32'h10,1,26'h40, 1,0, 32'h210, 32'h210));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,0, 32'h214, 32'h210));
    // wrap-around target, then reset mid-flush aborts it
    vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,32'h8,0,0, 1,0, 32'h4, 32'h4));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,0, RESET_PC, RESET_PC));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 32'h4, RESET_PC));
    // misaligned target
    vecs.push_back(mk(0,0,1,32'h102,32'h0,0,0, 1,0, mis_pc, mis_rpc));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,MIS, mis_pc + 32'd4, mis_rpc));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, mis_pc + 32'd8, mis_rpc));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].pc4, vecs[i].off,
           vecs[i].jmp, vecs[i].jidx);
      check($sformatf("vec%0d_flush", i), {31'd0, s_flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("vec%0d_trap", i), {31'd0, s_trap}, {31'd0, vecs[i].exp_trap});
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_rpc", i), redirect_pc, vecs[i].exp_rpc);
    end

    // Randomised run against the reference model.
    for (int k = 0; k < 500; k++) begin
      logic        r, s, b, j;
      logic [31:0] p4, off;
      logic [25:0] ji;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 25);
      b   = ($urandom_range(0, 99) < 12);
      j   = ($urandom_range(0, 99) < 12);
      p4  = $urandom;
      off = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        p4[1:0] = 2'b00; off[1:0] = 2'b00;
      end
      ji  = 26'($urandom);
      step(r, s, b, p4, off, j, ji);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
